video_timing: RTL and testbench



---
 rtl/video_pkg.sv | 42 ++++
 rtl/video_ctr.sv | 26 ++
 rtl/video_timing.sv | 103 ++++++++++
 tb/tb_video_timing.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared raster timing constants and helpers for the display pipeline.
package video_pkg;

    // 1920x1080@60 (148.5 MHz pixel clock)
    localparam int H1080_PIX   = 1920;
    localparam int H1080_FRONT = 88;
    localparam int H1080_SYNC  = 44;
    localparam int H1080_BACK  = 148;
    localparam int V1080_PIX   = 1080;
    localparam int V1080_FRONT = 4;
    localparam int V1080_SYNC  = 5;
    localparam int V1080_BACK  = 36;

    // 1280x720@60 (74.25 MHz pixel clock)
    localparam int H720_PIX    = 1280;
    localparam int H720_FRONT  = 110;
    localparam int H720_SYNC   = 40;
    localparam int H720_BACK   = 220;
    localparam int V720_PIX    = 720;
    localparam int V720_FRONT  = 5;
    localparam int V720_SYNC   = 5;
    localparam int V720_BACK   = 20;

    localparam logic SYNC_POS = 1'b1;
    localparam logic SYNC_NEG = 1'b0;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
        logic frame_start;
    } vt_flags_t;

    function automatic int htotal(int pix, int fp, int sw, int bp);
        return pix + fp + sw + bp;
    endfunction

    function automatic int vtotal(int pix, int fp, int sw, int bp);
        return pix + fp + sw + bp;
    endfunction

endpackage

// File: rtl/video_ctr.sv
// Modulo-MAX counter with enable; resets to MAX-1 so the first enable lands on 0.
module video_ctr #(
    parameter int MAX = 8,
    parameter int W   = $clog2(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] q,
    output logic [W-1:0] nxt,
    output logic         wrap
);

    assign wrap = (q == W'(MAX - 1));

    always_comb begin
        nxt = q;
        if (en) nxt = wrap ? '0 : q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= W'(MAX - 1);
        else     q <= nxt;
    end

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: counters, syncs, active and frame-start, all registered and aligned.
// Optional frame counter output enabled by defining VIDEO_TIMING_FRAME_CTR_EN.
module video_timing
    import video_pkg::*;
#(
    parameter int   HPIX      = H1080_PIX,
    parameter int   HFRONT    = H1080_FRONT,
    parameter int   HSYNC     = H1080_SYNC,
    parameter int   HBACK     = H1080_BACK,
    parameter int   VPIX      = V1080_PIX,
    parameter int   VFRONT    = V1080_FRONT,
    parameter int   VSYNC     = V1080_SYNC,
    parameter int   VBACK     = V1080_BACK,
    parameter logic HSYNC_POL = SYNC_POS,
    parameter logic VSYNC_POL = SYNC_POS,
`ifdef VIDEO_TIMING_FRAME_CTR_EN
    parameter int   FRAME_BITS = 16,
`endif
    parameter int   HCTR_BITS = $clog2(htotal(HPIX, HFRONT, HSYNC, HBACK)),
    parameter int   VCTR_BITS = $clog2(vtotal(VPIX, VFRONT, VSYNC, VBACK))
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_pix_en,
    output logic [HCTR_BITS-1:0] out_hpix,
    output logic [VCTR_BITS-1:0] out_vpix,
    output logic                 out_hsync,
    output logic                 out_vsync,
    output logic                 out_active,
    output logic                 out_frame_start
`ifdef VIDEO_TIMING_FRAME_CTR_EN
   ,output logic [FRAME_BITS-1:0] out_frame
`endif
);

    localparam int HTOTAL = htotal(HPIX, HFRONT, HSYNC, HBACK);
    localparam int VTOTAL = vtotal(VPIX, VFRONT, VSYNC, VBACK);
    localparam logic [31:0] HS_BEG = 32'(HPIX + HFRONT);
    localparam logic [31:0] HS_END = 32'(HPIX + HFRONT + HSYNC);
    localparam logic [31:0] VS_BEG = 32'(VPIX + VFRONT);
    localparam logic [31:0] VS_END = 32'(VPIX + VFRONT + VSYNC);

    logic [HCTR_BITS-1:0] hnext;
    logic [VCTR_BITS-1:0] vnext;
    logic                 hwrap, vwrap;
    vt_flags_t            flags_q, flags_n;

    video_ctr #(.MAX(HTOTAL), .W(HCTR_BITS)) u_hctr (
        .clk (in_clk),
        .rst (in_rst),
        .en  (in_pix_en),
        .q   (out_hpix),
        .nxt (hnext),
        .wrap(hwrap)
    );

    video_ctr #(.MAX(VTOTAL), .W(VCTR_BITS)) u_vctr (
        .clk (in_clk),
        .rst (in_rst),
        .en  (in_pix_en & hwrap),
        .q   (out_vpix),
        .nxt (vnext),
        .wrap(vwrap)
    );

    // Flags are decoded from the next counter values so they land with the counters.
    always_comb begin
        flags_n.hsync       = ((32'(hnext) >= HS_BEG) && (32'(hnext) < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        flags_n.vsync       = ((32'(vnext) >= VS_BEG) && (32'(vnext) < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
        flags_n.active      = (32'(hnext) < 32'(HPIX)) && (32'(vnext) < 32'(VPIX));
        flags_n.frame_start = in_pix_en & hwrap & vwrap;
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            flags_q.hsync       <= ~HSYNC_POL;
            flags_q.vsync       <= ~VSYNC_POL;
            flags_q.active      <= 1'b0;
            flags_q.frame_start <= 1'b0;
        end else begin
            if (in_pix_en) begin
                flags_q.hsync  <= flags_n.hsync;
                flags_q.vsync  <= flags_n.vsync;
                flags_q.active <= flags_n.active;
            end
            // Not gated by the strobe: the pulse must drop after one clock.
            flags_q.frame_start <= flags_n.frame_start;
        end
    end

    assign out_hsync       = flags_q.hsync;
    assign out_vsync       = flags_q.vsync;
    assign out_active      = flags_q.active;
    assign out_frame_start = flags_q.frame_start;

`ifdef VIDEO_TIMING_FRAME_CTR_EN
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst)                   out_frame <= '1;
        else if (flags_n.frame_start) out_frame <= out_frame + 1'b1;
    end
`endif

endmodule

// File: tb/tb_video_timing.sv
// Scoreboard bench for video_timing on an 8x6 raster; frame counter checked when its macro is set.
module tb_video_timing;

    logic       in_clk = 1'b0;
    logic       in_rst = 1'b1;
    logic       in_pix_en = 1'b0;
    logic [2:0] out_hpix;
    logic [2:0] out_vpix;
    logic       out_hsync, out_vsync, out_active, out_frame_start;
`ifdef VIDEO_TIMING_FRAME_CTR_EN
    logic [1:0] out_frame;
`endif

    always #5 in_clk = ~in_clk;

    video_timing #(
        .HPIX(4), .HFRONT(1), .HSYNC(2), .HBACK(1),
        .VPIX(3), .VFRONT(1), .VSYNC(1), .VBACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
`ifdef VIDEO_TIMING_FRAME_CTR_EN
        .FRAME_BITS(2),
`endif
        .HCTR_BITS(3), .VCTR_BITS(3)
    ) dut (
        .in_clk         (in_clk),
        .in_rst         (in_rst),
        .in_pix_en      (in_pix_en),
        .out_hpix       (out_hpix),
        .out_vpix       (out_vpix),
        .out_hsync      (out_hsync),
        .out_vsync      (out_vsync),
        .out_active     (out_active),
        .out_frame_start(out_frame_start)
`ifdef VIDEO_TIMING_FRAME_CTR_EN
       ,.out_frame      (out_frame)
`endif
    );

    typedef struct {
        int h, v, fr;
        bit hs, vs, act, fs;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   done  = 0;

    // reference raster position
    int eh = 7, ev = 5, efr = 3;
    bit efs = 0;

    function automatic exp_t make_exp();
        exp_t e;
        e.h   = eh;
        e.v   = ev;
        e.fr  = efr;
        e.fs  = efs;
        e.hs  = (eh == 5) || (eh == 6);
        e.vs  = (ev == 4);
        e.act = (eh < 4) && (ev < 3);
        return e;
    endfunction

    task automatic check(input string tag, input exp_t e);
        bit bad;
        n_vec++;
        bad = (int'(out_hpix) != e.h) || (int'(out_vpix) != e.v) || (out_hsync != e.hs) ||
              (out_vsync != e.vs) || (out_active != e.act) || (out_frame_start != e.fs);
`ifdef VIDEO_TIMING_FRAME_CTR_EN
        if (int'(out_frame) != e.fr) bad = 1;
`endif
        if (bad) begin
            n_bad++;
            $display("FAIL %s t=%0t got h=%0d v=%0d hs=%0b vs=%0b act=%0b fs=%0b want h=%0d v=%0d hs=%0b vs=%0b act=%0b fs=%0b fr=%0d",
                     tag, $time, out_hpix, out_vpix, out_hsync, out_vsync, out_active, out_frame_start,
                     e.h, e.v, e.hs, e.vs, e.act, e.fs, e.fr);
        end
    endtask

    // Drive one clock of stimulus and queue the state expected after the next rising edge.
    task automatic step(input bit rst, input bit en);
        @(negedge in_clk);
        in_rst    = rst;
        in_pix_en = en;
        if (rst) begin
            eh = 7; ev = 5; efr = 3; efs = 0;
        end else begin
            efs = 0;
            if (en) begin
                if (eh == 7) begin
                    eh = 0;
                    ev = (ev == 5) ? 0 : ev + 1;
                end else begin
                    eh = eh + 1;
                end
                if (eh == 0 && ev == 0) begin
                    efs = 1;
                    efr = (efr + 1) % 4;
                end
            end
        end
        sbq.push_back(make_exp());
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge in_clk);
            #2;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check("scoreboard", e);
            end
            if (done) break;
        end
    end

    initial begin : stim
        int guard;
        repeat (3) @(posedge in_clk);
        #3;
        check("reset_state", make_exp());

        // free run two frames: hsync, vsync, active, frame_start period
        for (int i = 0; i < 96; i++) step(0, 1);

        // strobe 1-of-3
        for (int i = 0; i < 30; i++) begin
            step(0, 1);
            step(0, 0);
            step(0, 0);
        end

        // advance to (2,1) then assert reset asynchronously mid-cycle
        guard = 0;
        while (!(eh == 2 && ev == 1) && guard < 100) begin
            step(0, 1);
            guard++;
        end
        if (guard >= 100) begin
            n_vec++;
            n_bad++;
            $display("FAIL reach_2_1 got h=%0d v=%0d want h=2 v=1", eh, ev);
        end
        @(posedge in_clk);
        #4;
        in_rst = 1'b1;
        eh = 7; ev = 5; efr = 3; efs = 0;
        #1;
        check("async_reset", make_exp());
        for (int i = 0; i < 3; i++) step(1, 1);

        // recover and run another frame plus a bit
        for (int i = 0; i < 60; i++) step(0, 1);
        for (int i = 0; i < 4; i++) step(0, 0);

        guard = 0;
        while (sbq.size() != 0 && guard < 20) begin
            @(posedge in_clk);
            guard++;
        end
        #3;
        if (sbq.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain got %0d pending want 0", sbq.size());
        end
        done = 1;
        @(posedge in_clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
